// File: rtl/caf_index_sequencer_if.sv
// Index bus between the CAF index sequencer and the reference sample buffer.
//   index_rvalid  : index_rdata carries a valid buffer index
//   index_rdata   : buffer index
//   index_rready  : buffer accepts the index this cycle
//   window_last   : qualifies index_rvalid, last index of the current shift
//   sweep_last    : qualifies index_rvalid, last index of the whole sweep
// master = sequencer side, slave = buffer side.
interface caf_index_sequencer_if #(
   parameter int index_bits = 4
);
   logic                  index_rvalid;
   logic [index_bits-1:0] index_rdata;
   logic                  index_rready;
   logic                  window_last;
   logic                  sweep_last;

   modport master (
      output index_rvalid,
      output index_rdata,
      output window_last,
      output sweep_last,
      input  index_rready
   );

   modport slave (
      input  index_rvalid,
      input  index_rdata,
      input  window_last,
      input  sweep_last,
      output index_rready
   );
endinterface

// File: rtl/caf_index_sequencer.sv
// CAF reference-buffer index sequencer.
// On start, sweeps a correlation window across the reference buffer: for each
// shift s it issues s, s+1, ..., s+window_length-1 over a valid/ready bus,
// then advances s. Window and sweep boundaries are flagged for the accumulator.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle sweep request, sampled only in IDLE
//   abort         : ends a running sweep without a done pulse
//   index_bus     : index valid/data/ready plus window_last/sweep_last (master)
//   shift_idx     : current shift s, held after the sweep until the next start
//   busy          : high while the sweep is running
//   done          : one-cycle pulse after a normally completed sweep
//
// Optional feature macro: CAF_INDEX_WRAP_EN
//   defined   : index = (s+k) mod buffer_length, all num_shifts shifts issued
//   undefined : no wrap, shifts that would run past the buffer end are dropped
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | waiting for start, bus idle
// RUN   | issuing indices, k = offset in window, s = shift
// DONE  | one-cycle done pulse, then back to IDLE
module caf_index_sequencer #(
   parameter int buffer_length = 10,
   parameter int index_bits    = 4,
   parameter int window_length = 8,
   parameter int num_shifts    = 3,
   parameter int shift_bits    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   caf_index_sequencer_if.master  index_bus,
   output logic [shift_bits-1:0]  shift_idx,
   output logic                   busy,
   output logic                   done
);

`ifdef CAF_INDEX_WRAP_EN
   localparam int eff_shifts = num_shifts;
`else
   // only shifts whose whole window fits inside the buffer are issued
   localparam int fit_shifts = buffer_length - window_length + 1;
   localparam int eff_shifts = (num_shifts < fit_shifts) ? num_shifts : fit_shifts;
`endif

   localparam logic [shift_bits-1:0] last_shift = shift_bits'(eff_shifts - 1);
   localparam logic [index_bits-1:0] last_k     = index_bits'(window_length - 1);
   // one bit wider than either operand so s+k never overflows before reduction
   localparam int sum_w = ((index_bits > shift_bits) ? index_bits : shift_bits) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [shift_bits-1:0] s_q, s_d;
   logic [index_bits-1:0] k_q, k_d;
   logic                  xfer;
   logic                  win_end;
   logic [sum_w-1:0]      sum;
   logic [index_bits-1:0] idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         k_q     <= k_d;
      end
   end

   assign xfer    = (state_q == RUN) && index_bus.index_rready;
   assign win_end = (k_q == last_k);

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               s_d     = '0;
               k_d     = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (xfer) begin
               if (win_end) begin
                  k_d = '0;
                  if (s_q == last_shift) begin
                     state_d = DONE;
                  end else begin
                     s_d = s_q + shift_bits'(1);
                  end
               end else begin
                  k_d = k_q + index_bits'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sum = sum_w'(s_q) + sum_w'(k_q);

`ifdef CAF_INDEX_WRAP_EN
   assign idx = index_bits'(sum % sum_w'(buffer_length));
`else
   assign idx = index_bits'(sum);
`endif

   assign index_bus.index_rvalid = (state_q == RUN);
   // data is forced to zero whenever the bus is idle
   assign index_bus.index_rdata  = (state_q == RUN) ? idx : '0;
   assign index_bus.window_last  = (state_q == RUN) && win_end;
   assign index_bus.sweep_last   = (state_q == RUN) && win_end && (s_q == last_shift);

   assign shift_idx = s_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule
